// File: rtl/conv_mac.sv
// 3x3 convolution multiply-accumulate stage: consumes the serial 9-tap window stream,
// accumulates pixel*coefficient products, then shifts, clamps and emits one pixel per window.
module conv_mac #(
  parameter int DataBitWidth    = 12,
  parameter int CoefBitWidth    = 8,
  parameter int AddressBitWidth = 17,
  parameter int AccBitWidth     = 26,
  parameter int Shift           = 4,
  parameter int NoOfWindows     = 25
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       coef_we,
  input  logic [3:0]                 coef_addr,
  input  logic [CoefBitWidth-1:0]    coef_in,
  input  logic                       pix_valid,
  input  logic [DataBitWidth-1:0]    pix_in,
  output logic                       res_valid,
  output logic [DataBitWidth-1:0]    res_data,
  output logic [AddressBitWidth-1:0] WriteAddress,
  output logic                       busy,
  output logic                       done,
  output logic [1:0]                 state_dbg
);

  localparam int ProdBitWidth = DataBitWidth + CoefBitWidth + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]                        state;
  logic signed [CoefBitWidth-1:0]    coef [9];
  logic [3:0]                        tap_cnt;
  logic [AddressBitWidth-1:0]        win_cnt;
  logic                              all_fed;

  logic                              s1_valid;
  logic [3:0]                        s1_tap;
  logic                              s1_last_win;
  logic [AddressBitWidth-1:0]        s1_win;
  logic signed [AccBitWidth-1:0]     s1_prod;

  logic                              s2_valid;
  logic                              s2_last_win;
  logic [AddressBitWidth-1:0]        s2_win;
  logic signed [AccBitWidth-1:0]     acc;

  logic                              tap_take;
  logic                              last_win;
  logic signed [CoefBitWidth-1:0]    coef_sel;
  logic signed [ProdBitWidth-1:0]    pix_wide;
  logic signed [ProdBitWidth-1:0]    coef_wide;
  logic signed [ProdBitWidth-1:0]    prod;
  logic signed [AccBitWidth-1:0]     scaled;
  logic [DataBitWidth-1:0]           clamped;

  // pix_valid has no backpressure: every pix_valid cycle in RUN is consumed as one tap
  // until the last tap of the image has been taken; later valids are dropped.
  assign tap_take  = (state == ST_RUN) && pix_valid && !all_fed;
  assign last_win  = (win_cnt == AddressBitWidth'(NoOfWindows - 1));
  assign coef_sel  = coef[tap_cnt];
  assign pix_wide  = {{(CoefBitWidth + 1){1'b0}}, pix_in};
  assign coef_wide = {{(DataBitWidth + 1){coef_sel[CoefBitWidth-1]}}, coef_sel};
  assign prod      = pix_wide * coef_wide;
  assign scaled    = acc >>> Shift;

  always_comb begin
    clamped = scaled[DataBitWidth-1:0];
    if (scaled[AccBitWidth-1]) begin
      clamped = '0;
    end else if (|scaled[AccBitWidth-2:DataBitWidth]) begin
      clamped = '1;
    end
  end

  assign busy      = (state == ST_RUN);
  assign done      = (state == ST_DONE);
  assign state_dbg = state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= ST_IDLE;
      for (int i = 0; i < 9; i++) coef[i] <= '0;
      tap_cnt      <= '0;
      win_cnt      <= '0;
      all_fed      <= 1'b0;
      s1_valid     <= 1'b0;
      s1_tap       <= '0;
      s1_last_win  <= 1'b0;
      s1_win       <= '0;
      s1_prod      <= '0;
      s2_valid     <= 1'b0;
      s2_last_win  <= 1'b0;
      s2_win       <= '0;
      acc          <= '0;
      res_valid    <= 1'b0;
      res_data     <= '0;
      WriteAddress <= '0;
    end else begin
      res_valid <= 1'b0;

      s1_valid <= tap_take;
      if (tap_take) begin
        s1_prod     <= {{(AccBitWidth - ProdBitWidth){prod[ProdBitWidth-1]}}, prod};
        s1_tap      <= tap_cnt;
        s1_last_win <= last_win;
        s1_win      <= win_cnt;
      end

      // Tap 0 reloads the accumulator, so back-to-back windows need no clear cycle.
      s2_valid <= s1_valid && (s1_tap == 4'd8);
      if (s1_valid) begin
        acc         <= (s1_tap == 4'd0) ? s1_prod : acc + s1_prod;
        s2_last_win <= s1_last_win;
        s2_win      <= s1_win;
      end

      if (s2_valid) begin
        res_valid    <= 1'b1;
        res_data     <= clamped;
        WriteAddress <= s2_win;
      end

      case (state)
        ST_IDLE: begin
          if (coef_we && coef_addr <= 4'd8) coef[coef_addr] <= coef_in;
          if (start) begin
            state        <= ST_RUN;
            tap_cnt      <= '0;
            win_cnt      <= '0;
            all_fed      <= 1'b0;
            WriteAddress <= '0;
          end
        end
        ST_RUN: begin
          if (tap_take) begin
            if (tap_cnt == 4'd8) begin
              tap_cnt <= '0;
              if (last_win) all_fed <= 1'b1;
              else          win_cnt <= win_cnt + 1'b1;
            end else begin
              tap_cnt <= tap_cnt + 4'd1;
            end
          end
          if (s2_valid && s2_last_win) state <= ST_DONE;
        end
        ST_DONE: begin
          if (start) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv_mac.sv
// Bench for conv_mac: table of kernel/image runs checked through a result scoreboard,
// plus hand-written reset and idle sequences.
module tb_conv_mac;
  localparam int DW = 12;
  localparam int CW = 8;
  localparam int AW = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          coef_we;
  logic [3:0]    coef_addr;
  logic [CW-1:0] coef_in;
  logic          pix_valid;
  logic [DW-1:0] pix_in;
  logic          res_valid;
  logic [DW-1:0] res_data;
  logic [AW-1:0] WriteAddress;
  logic          busy;
  logic          done;
  logic [1:0]    state_dbg;

  conv_mac dut (
    .clk(clk), .rst(rst), .start(start), .coef_we(coef_we), .coef_addr(coef_addr),
    .coef_in(coef_in), .pix_valid(pix_valid), .pix_in(pix_in), .res_valid(res_valid),
    .res_data(res_data), .WriteAddress(WriteAddress), .busy(busy), .done(done),
    .state_dbg(state_dbg)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [AW+DW-1:0] exp_q[$];
  int               lat_q[$];
  int               rcv_cnt = 0;
  int               res_mem[25];
  int               mcoef[9];
  int               img[25];
  logic [AW+DW-1:0] mon_e;
  int               mon_t;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (res_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_res", 1, 0);
      end else begin
        mon_e = exp_q.pop_front();
        mon_t = lat_q.pop_front();
        check("res_data", res_data, mon_e[DW-1:0]);
        check("res_addr", WriteAddress, mon_e[AW+DW-1:DW]);
        check("latency", cyc - mon_t, 2);
        if (WriteAddress < 25) res_mem[int'(WriteAddress)] = int'(res_data);
        rcv_cnt++;
      end
    end
  end

  // ---------------- model ----------------
  function automatic int tap_pix(input int w, input int k);
    int rr, cc;
    rr = w / 5 + (k % 3) - 1;
    cc = w % 5 + (k / 3) - 1;
    return (rr >= 0 && rr < 5 && cc >= 0 && cc < 5) ? img[rr * 5 + cc] : 0;
  endfunction

  function automatic int model(input int w);
    int sum, s;
    sum = 0;
    for (int k = 0; k < 9; k++) sum += tap_pix(w, k) * mcoef[k];
    s = sum >>> 4;
    return (s < 0) ? 0 : ((s > 4095) ? 4095 : s);
  endfunction

  // ---------------- driver tasks ----------------
  task automatic load_and_start();
    coef_we = 1'b1;
    for (int a = 0; a < 8; a++) begin
      coef_addr = 4'(a);
      coef_in   = CW'(mcoef[a]);
      @(posedge clk); #1;
    end
    coef_addr = 4'd12;
    coef_in   = 8'd99;
    @(posedge clk); #1;
    // The last coefficient rides along with start.
    coef_addr = 4'd8;
    coef_in   = CW'(mcoef[8]);
    start     = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    coef_we = 1'b0;
    rcv_cnt = 0;
    check("start_busy", busy, 1);
    check("start_addr_clr", WriteAddress, 0);
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start   = 1'b0;
    rcv_cnt = 0;
    check("start_state", state_dbg, 1);
  endtask

  task automatic feed(input int pct, input bit poison, input int ntaps);
    int w, k, nb;
    for (int t = 0; t < ntaps; t++) begin
      w  = t / 9;
      k  = t % 9;
      nb = ($urandom_range(0, 99) < pct) ? $urandom_range(1, 3) : 0;
      for (int b = 0; b < nb; b++) begin
        pix_valid = 1'b0;
        pix_in    = DW'($urandom);
        @(posedge clk); #1;
      end
      pix_valid = 1'b1;
      pix_in    = DW'(tap_pix(w, k));
      if (poison) begin
        coef_we   = 1'b1;
        coef_addr = 4'($urandom_range(0, 15));
        coef_in   = 8'd99;
      end
      @(posedge clk); #1;
      if (k == 8) begin
        exp_q.push_back({AW'(w), DW'(model(w))});
        lat_q.push_back(cyc);
      end
    end
    pix_valid = 1'b0;
    coef_we   = 1'b0;
  endtask

  task automatic finish_run();
    int i;
    // Taps beyond the last window must be dropped.
    for (int e = 0; e < 3; e++) begin
      pix_valid = 1'b1;
      pix_in    = 12'hfff;
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    i = 0;
    while (!done && i < 20) begin
      @(posedge clk); #1;
      i++;
    end
    check("done_flag", done, 1);
    check("busy_in_done", busy, 0);
    check("rcv_cnt", rcv_cnt, 25);
    check("q_empty", exp_q.size(), 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("hold_addr", WriteAddress, 24);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("done_clear", done, 0);
    check("back_idle", state_dbg, 0);
  endtask

  task automatic fill_img(input int mode);
    for (int r = 0; r < 5; r++)
      for (int c = 0; c < 5; c++)
        case (mode)
          0:       img[r * 5 + c] = 10 * r + c;
          1:       img[r * 5 + c] = 100;
          2:       img[r * 5 + c] = 4095;
          default: img[r * 5 + c] = 50;
        endcase
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [8:0][7:0] kern;
    logic [2:0]      mode;
    logic [6:0]      pct;
    logic            poison;
    logic [4:0]      chk_win;
    logic [11:0]     chk_val;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '0; vecs[0].kern[4] = 8'd16; vecs[0].mode = 3'd0;
    vecs[0].chk_win = 5'd12; vecs[0].chk_val = 12'd22;
    vecs[1] = '0; vecs[1].kern = {9{8'd16}}; vecs[1].mode = 3'd1;
    vecs[1].chk_win = 5'd12; vecs[1].chk_val = 12'd900;
    vecs[2] = '0; vecs[2].kern = {9{8'd16}}; vecs[2].mode = 3'd1; vecs[2].pct = 7'd30;
    vecs[2].chk_win = 5'd0; vecs[2].chk_val = 12'd400;
    vecs[3] = '0; vecs[3].kern = {9{8'd127}}; vecs[3].mode = 3'd2;
    vecs[3].chk_win = 5'd12; vecs[3].chk_val = 12'd4095;
    vecs[4] = '0; vecs[4].kern = {9{8'hff}}; vecs[4].mode = 3'd3;
    vecs[4].chk_win = 5'd12; vecs[4].chk_val = 12'd0;
    vecs[5] = '0; vecs[5].kern[4] = 8'd16; vecs[5].mode = 3'd0; vecs[5].pct = 7'd40;
    vecs[5].poison = 1'b1; vecs[5].chk_win = 5'd7; vecs[5].chk_val = 12'd12;
    vecs[6] = '0; vecs[6].kern[0] = 8'hf0; vecs[6].kern[4] = 8'd8; vecs[6].kern[8] = 8'd32;
    vecs[6].mode = 3'd0; vecs[6].pct = 7'd20; vecs[6].poison = 1'b1;
    vecs[6].chk_win = 5'd12; vecs[6].chk_val = 12'd66;

    rst = 1'b1; start = 1'b0; coef_we = 1'b0; coef_addr = '0; coef_in = '0;
    pix_valid = 1'b0; pix_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_addr", WriteAddress, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_state", state_dbg, 0);
    rst = 1'b0;

    // pix_valid in IDLE is ignored
    pix_valid = 1'b1; pix_in = 12'd777;
    repeat (3) begin
      @(posedge clk); #1;
    end
    pix_valid = 1'b0;
    check("idle_ignores_pix", state_dbg, 0);

    for (int i = 0; i < 7; i++) begin
      for (int k = 0; k < 9; k++) mcoef[k] = int'($signed(vecs[i].kern[k]));
      fill_img(int'(vecs[i].mode));
      load_and_start();
      feed(int'(vecs[i].pct), vecs[i].poison, 225);
      finish_run();
      check($sformatf("tbl%0d_win%0d", i, vecs[i].chk_win),
            res_mem[int'(vecs[i].chk_win)], vecs[i].chk_val);
    end

    // Reset in the middle of window 7, right after its tap 3.
    for (int k = 0; k < 9; k++) mcoef[k] = (k == 4) ? 16 : 0;
    fill_img(0);
    load_and_start();
    feed(0, 1'b0, 7 * 9 + 4);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("mid_rst_rcv", rcv_cnt, 7);
    check("mid_rst_q", exp_q.size(), 0);
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_data", res_data, 0);
    check("mid_rst_addr", WriteAddress, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_state", state_dbg, 0);
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("mid_rst_quiet", rcv_cnt, 7);

    // Coefficients were cleared by reset, so every result is zero.
    for (int k = 0; k < 9; k++) mcoef[k] = 0;
    do_start();
    feed(10, 1'b0, 225);
    finish_run();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
